// File: rtl/count_seq_checker.sv
// In-design monitor for a WIDTH-bit enable-gated counter: checks every step of
// count against the enable history and reports events through a one-entry slot.
module count_seq_checker #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 10,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [WIDTH-1:0] evt_value,
    output logic             over_limit,
    output logic             evt_dropped,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0]       CODE_STEP = 2'd0;
    localparam logic [1:0]       CODE_OVER = 2'd1;
    localparam logic [1:0]       CODE_WRAP = 2'd2;
    localparam logic [WIDTH-1:0] LIMIT_V   = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [ERR_W-1:0] ONE_E     = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    // state is the observable FSM status for checkers bound to this block
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic [WIDTH-1:0] expected;
    logic             checking;
    logic             over_now;
    logic             prev_over;
    logic             ol_fire;
    logic             step_fire;
    logic             wrap_fire;
    logic             det;
    logic [1:0]       det_code;
    logic             accept;
    logic             load;
    logic             drop;

    // Value the counter must show now, given what it showed and was told last cycle.
    always_comb begin
        expected = prev_count;
        if (prev_en) begin
            expected = (prev_count == LIMIT_V) ? '0 : prev_count + ONE_W;
        end
    end

    always_comb begin
        state_next = state;
        ol_fire    = 1'b0;
        over_now   = (count > LIMIT_V);
        prev_over  = (prev_count > LIMIT_V);
        unique case (state)
            IDLE: begin
                state_next = TRACK;
            end
            TRACK: begin
                ol_fire = over_now;
                if (over_now) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                // Once faulted, only a fresh excursion above the limit is reported.
                ol_fire = over_now && !prev_over;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        checking  = (state != IDLE);
        step_fire = checking && !ol_fire && (count != expected);
        wrap_fire = checking && prev_en && (prev_count == LIMIT_V) && (count == '0);
        det       = ol_fire || step_fire || wrap_fire;
        det_code  = CODE_WRAP;
        if (ol_fire) begin
            det_code = CODE_OVER;
        end else if (step_fire) begin
            det_code = CODE_STEP;
        end
    end

    // Valid/ready slot: an event transfers on a cycle where evt_valid && evt_ready
    // at posedge; while evt_valid && !evt_ready, evt_code/evt_value hold stable.
    always_comb begin
        accept = evt_valid && evt_ready;
        load   = det && (!evt_valid || evt_ready);
        drop   = det && evt_valid && !evt_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            prev_count  <= '0;
            prev_en     <= 1'b0;
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_value   <= '0;
            over_limit  <= 1'b0;
            evt_dropped <= 1'b0;
            err_count   <= '0;
        end else begin
            state      <= state_next;
            prev_count <= count;
            prev_en    <= enable;
            if (load) begin
                evt_valid <= 1'b1;
                evt_code  <= det_code;
                evt_value <= count;
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
            if (drop) begin
                evt_dropped <= 1'b1;
            end
            if (ol_fire) begin
                over_limit <= 1'b1;
            end
            if ((ol_fire || step_fire) && (err_count != ERR_MAX)) begin
                err_count <= err_count + ONE_E;
            end
        end
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream consumer of the 4-bit enable-gated counter. Samples `count` and `enable` every cycle.
- Checks that each step of `count` matches the enable history, and detects legal wraps and limit violations.
- Reports each event through a single-entry valid/ready event port and keeps sticky and saturating error status.
- Sits alongside the counter as a synthesizable, in-design monitor, feeding a status/interrupt collector.

Parameters:
- WIDTH, 4, width of the monitored count.
- LIMIT, 10, maximum legal count value; a legal step from LIMIT goes to 0.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- enable  input  1  counter enable, as driven to the counter.
- count  input  WIDTH  counter output.
- evt_valid  output  1  event pending.
- evt_ready  input  1  consumer accepts event.
- evt_code  output  2  event code: 0 = STEP_ERR, 1 = OVER_LIMIT, 2 = WRAP.
- evt_value  output  WIDTH  count value that caused the event.
- over_limit  output  1  sticky; set once count > LIMIT is seen.
- evt_dropped  output  1  sticky; an event was lost because the slot was full.
- err_count  output  ERR_W  saturating count of STEP_ERR and OVER_LIMIT detections.

Behaviour:
- Reset, when reset==0 at posedge:
  - state=IDLE; prev_count=0; prev_en=0.
  - evt_valid=0, evt_code=0, evt_value=0.
  - over_limit=0, evt_dropped=0, err_count=0.
  - Any pending event is discarded, including on a mid-operation reset.
- Registers prev_count and prev_en capture count and enable every non-reset cycle.
- expected = prev_en ? ((prev_count==LIMIT) ? 0 : prev_count+1) : prev_count.
  - The +1 is computed in WIDTH bits.
- States:
  - IDLE: first non-reset cycle captures the baseline only; no checks are made. Then go to TRACK.
  - TRACK: checks every cycle. Go to FAULT on OVER_LIMIT detection.
  - FAULT: over_limit held at 1; checks continue. Leaves only via reset.
- Detection, in TRACK and FAULT, on the sampled count, same cycle as sampling:
  - OVER_LIMIT: count > LIMIT. Fires on every such cycle while in TRACK. In FAULT, fires only on the transition from count<=LIMIT to count>LIMIT.
  - STEP_ERR: count != expected, and OVER_LIMIT did not fire this cycle.
  - WRAP: prev_en==1, prev_count==LIMIT and count==0.
  - Priority when several apply: OVER_LIMIT > STEP_ERR > WRAP. At most one event per cycle.
- err_count increments by 1 per STEP_ERR or OVER_LIMIT detection, whether or not the event is delivered. It saturates at 2^ERR_W-1.
- Event slot:
  - A detected event loads evt_code and evt_value with evt_valid=1 at the next posedge (latency 1 cycle).
  - The slot loads if it is empty, or if evt_valid && evt_ready in that same cycle (accept and reload back-to-back).
  - If the slot is full and not accepted, the new event is dropped and evt_dropped is set (sticky). The held event stays stable.
  - evt_valid is cleared on accept when no new event is detected.
  - evt_code and evt_value must not change while evt_valid==1 && evt_ready==0.
- over_limit is set on the same posedge that loads the OVER_LIMIT event (or that would load it, if dropped).

Test Plan:
- Reset held 0 for 3 cycles, then release with count=0 and enable=0 for 5 cycles -> all outputs 0, no events, state goes IDLE then TRACK.
- enable=1, count driven 0,1,...,10,0,1 -> exactly one WRAP event with evt_value=0, and err_count=0.
- enable=1, count jumps 3 to 5 -> STEP_ERR with evt_value=5 and evt_valid high the next cycle; err_count=1.
- count=12 held for 4 cycles with evt_ready=1 -> one OVER_LIMIT event with evt_value=12; over_limit=1 stays high; err_count=1.
- evt_ready=0 with a STEP_ERR pending, then a second STEP_ERR -> first event held stable, evt_dropped=1, err_count=2. Raising evt_ready delivers only the first event.
- Reset pulsed to 0 while evt_valid=1 and over_limit=1 -> next cycle all outputs 0; the first post-reset sample raises no event.
